master_ctrl_sm: RTL and testbench



---
 rtl/master_ctrl_sm_pkg.sv | 58 +++++
 rtl/master_ctrl_sm_if.sv | 21 ++
 rtl/master_ctrl_sm_cycle_counter.sv | 33 +++
 rtl/master_ctrl_sm.sv | 87 ++++++++
 tb/tb_master_ctrl_sm.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/master_ctrl_sm_pkg.sv
// Shared codes for the master control SM and the slave SMs that decode
// its MASTER_STATE command bus.
package master_ctrl_sm_pkg;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'b00,
    MS_ARMED = 2'b01,
    MS_DONE  = 2'b10,
    MS_RUN   = 2'b11
  } ms_cmd_e;

  localparam logic [3:0] DONE_CODE_DEF = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4,
    ST_CLR   = 3'd5
  } st_e;

  typedef struct packed {
    ms_cmd_e cmd;
    logic    slv_rst;
    logic    busy;
    logic    fault;
  } out_t;

  // Slaves are held in reset alongside the master.
  localparam out_t RST_OUT = '{
    cmd: MS_IDLE, slv_rst: 1'b1, busy: 1'b0, fault: 1'b0
  };

  function automatic out_t decode_out(st_e s);
    out_t o;
    o = '{cmd: MS_IDLE, slv_rst: 1'b0, busy: 1'b0, fault: 1'b0};
    case (s)
      ST_ARMED: begin
        o.cmd  = MS_ARMED;
        o.busy = 1'b1;
      end
      ST_RUN: begin
        o.cmd  = MS_RUN;
        o.busy = 1'b1;
      end
      ST_DONE:  o.cmd = MS_DONE;
      ST_FAULT: begin
        o.cmd   = MS_DONE;
        o.fault = 1'b1;
      end
      ST_CLR:   o.slv_rst = 1'b1;
      default:  o.cmd = MS_IDLE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/master_ctrl_sm_if.sv
// Command/readback bundle between the master SM and its slaves.
interface master_ctrl_sm_if;
  logic       START;
  logic       CLEAR;
  logic [3:0] SLAVE_STATE;
  logic [1:0] MASTER_STATE;
  logic       SLAVE_RESET;
  logic       BUSY;
  logic       FAULT;
  logic [2:0] MASTER_SM_OUT;

  modport master (
    input  START, CLEAR, SLAVE_STATE,
    output MASTER_STATE, SLAVE_RESET, BUSY, FAULT, MASTER_SM_OUT
  );

  modport slave (
    output START, CLEAR, SLAVE_STATE,
    input  MASTER_STATE, SLAVE_RESET, BUSY, FAULT, MASTER_SM_OUT
  );
endinterface

// File: rtl/master_ctrl_sm_cycle_counter.sv
// Per-state cycle counter with clear, enable and terminal-count compare.
module master_ctrl_sm_cycle_counter #(
  parameter int CNT_W = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc,
  output logic             at_tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign at_tc = (cnt_q == tc);

endmodule

// File: rtl/master_ctrl_sm.sv
// Master control SM: arms, runs and supervises a slave SM, then
// re-arms it with a one-cycle slave reset.
module master_ctrl_sm
  import master_ctrl_sm_pkg::*;
#(
  parameter int         ARM_CYCLES     = 50000000,
  parameter int         TIMEOUT_CYCLES = 500000000,
  parameter int         CNT_W          = 29,
  parameter logic [3:0] DONE_CODE      = DONE_CODE_DEF
) (
  input logic              CLK,
  input logic              RESET,
  master_ctrl_sm_if.master bus
);

  localparam logic [CNT_W-1:0] ARM_TC = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TC  = CNT_W'(TIMEOUT_CYCLES - 1);

  st_e  state_q;
  st_e  state_d;
  out_t out_q;
  out_t out_d;

  logic [CNT_W-1:0] tc;
  logic             at_tc;
  logic             cnt_en;
  logic             cnt_clr;

  assign tc      = (state_q == ST_ARMED) ? ARM_TC : TO_TC;
  assign cnt_en  = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign cnt_clr = (state_d != state_q);

  master_ctrl_sm_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (CLK),
    .rst_n(RESET),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tc   (tc),
    .at_tc(at_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (bus.START) state_d = ST_ARMED;
      ST_ARMED:
        if (at_tc) state_d = ST_RUN;
      // Completion outranks timeout on the same cycle.
      ST_RUN:
        if (bus.SLAVE_STATE == DONE_CODE)
          state_d = ST_DONE;
        else if (at_tc)
          state_d = ST_FAULT;
      ST_DONE, ST_FAULT:
        if (bus.CLEAR) state_d = ST_CLR;
      ST_CLR:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q.
  always_comb begin
    out_d = decode_out(state_d);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      out_q   <= RST_OUT;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign bus.MASTER_STATE  = out_q.cmd;
  assign bus.SLAVE_RESET   = out_q.slv_rst;
  assign bus.BUSY          = out_q.busy;
  assign bus.FAULT         = out_q.fault;
  assign bus.MASTER_SM_OUT = state_q;

endmodule

// File: tb/tb_master_ctrl_sm.sv
// Bench for master_ctrl_sm: directed sequences plus random stimulus,
// all checked every cycle against a phase/elapsed-cycle model.
module tb_master_ctrl_sm;

  localparam int ARM = 4;
  localparam int TMO = 20;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  master_ctrl_sm_if bus();

  master_ctrl_sm #(
    .ARM_CYCLES    (ARM),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (29),
    .DONE_CODE     (4'hF)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle,1 armed,2 run,3 done,4 fault,5 clr;
  // el = cycles spent so far in the phase.
  int m_ph = 0;
  int m_el = 0;
  bit m_rst_seen = 0;
  bit m_valid = 0;

  function automatic logic [1:0] cmd_of(int ph);
    logic [1:0] t [6];
    t = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00};
    return t[ph];
  endfunction

  always @(posedge clk) begin
    m_valid = 1;
    if (!rst_n) begin
      m_ph = 0;
      m_el = 0;
      m_rst_seen = 1;
    end else begin
      m_rst_seen = 0;
      m_el = m_el + 1;
      case (m_ph)
        0: if (bus.START) begin m_ph = 1; m_el = 0; end
        1: if (m_el == ARM) begin m_ph = 2; m_el = 0; end
        2: if (bus.SLAVE_STATE == 4'hF) begin m_ph = 3; m_el = 0; end
           else if (m_el == TMO) begin m_ph = 4; m_el = 0; end
        3, 4: if (bus.CLEAR) begin m_ph = 5; m_el = 0; end
        default: begin m_ph = 0; m_el = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_state", bus.MASTER_STATE, cmd_of(m_ph));
      chk("m_smout", bus.MASTER_SM_OUT, m_ph);
      chk("m_busy", bus.BUSY, (m_ph == 1 || m_ph == 2));
      chk("m_fault", bus.FAULT, (m_ph == 4));
      chk("m_srst", bus.SLAVE_RESET, (m_rst_seen || m_ph == 5));
    end
  end

  // Count cycles MASTER_STATE stays at v; ends on first negedge where it differs.
  task automatic run_len(input logic [1:0] v, output int n);
    n = 0;
    while (bus.MASTER_STATE == v && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_clear();
    bus.CLEAR = 1'b1;
    @(negedge clk);
    chk("clr_smout", bus.MASTER_SM_OUT, 3'd5);
    chk("clr_srst", bus.SLAVE_RESET, 1'b1);
    bus.CLEAR = 1'b0;
    @(negedge clk);
    chk("clr_idle", bus.MASTER_SM_OUT, 3'd0);
    chk("clr_srst_off", bus.SLAVE_RESET, 1'b0);
    @(negedge clk);
    chk("retrigger", bus.MASTER_STATE, 2'b01);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    bus.START = 1'b1;
    bus.CLEAR = 1'b0;
    bus.SLAVE_STATE = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.MASTER_STATE, 2'b00);
    chk("rst_srst", bus.SLAVE_RESET, 1'b1);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_fault", bus.FAULT, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_armed", bus.MASTER_STATE, 2'b01);

    // Normal completion after 10 RUN cycles
    run_len(2'b01, n);
    chk("arm_len", n, ARM);
    chk("run_entry", bus.MASTER_STATE, 2'b11);
    repeat (9) @(negedge clk);
    bus.SLAVE_STATE = 4'hF;
    @(negedge clk);
    bus.SLAVE_STATE = 4'h0;
    chk("done_state", bus.MASTER_STATE, 2'b10);
    chk("done_smout", bus.MASTER_SM_OUT, 3'd3);
    chk("done_fault", bus.FAULT, 1'b0);
    do_clear();

    // Timeout with slave stuck at 3
    bus.SLAVE_STATE = 4'h3;
    run_len(2'b01, n);
    run_len(2'b11, n);
    chk("tmo_len", n, TMO);
    chk("tmo_fault", bus.FAULT, 1'b1);
    chk("tmo_state", bus.MASTER_STATE, 2'b10);
    do_clear();

    // Completion on the same cycle as the timeout
    run_len(2'b01, n);
    repeat (TMO - 1) @(negedge clk);
    bus.SLAVE_STATE = 4'hF;
    @(negedge clk);
    bus.SLAVE_STATE = 4'h0;
    chk("sim_state", bus.MASTER_STATE, 2'b10);
    chk("sim_fault", bus.FAULT, 1'b0);
    do_clear();

    // Reset mid-RUN at counter 7
    run_len(2'b01, n);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_smout", bus.MASTER_SM_OUT, 3'd0);
    chk("mrst_state", bus.MASTER_STATE, 2'b00);
    chk("mrst_srst", bus.SLAVE_RESET, 1'b1);
    rst_n = 1'b1;
    bus.START = 1'b0;
    @(negedge clk);
    chk("mrst_idle", bus.MASTER_SM_OUT, 3'd0);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 1500; i++) begin
      bus.START = ($urandom_range(0, 2) == 0);
      bus.CLEAR = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0)
        bus.SLAVE_STATE = 4'hF;
      else
        bus.SLAVE_STATE = 4'($urandom_range(0, 14));
      rst_n = ($urandom_range(0, 59) != 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
